ftdi_tx_bridge: RTL

FTDI_TX_BRIDGE -- requirements
Module: ftdi_tx_bridge

---
 rtl/ftdi_tx_bridge.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/ftdi_tx_bridge.sv
// Word FIFO feeding a byte serializer toward an FTDI engine; loopback mode
// re-queues received bytes. States: IDLE | nothing presented, SEND | byte at idx presented.
module ftdi_tx_bridge #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     sw_clr,
  input  logic                     loop_en,
  input  logic [DATA_W-1:0]        src_data,
  input  logic                     src_valid,
  output logic                     src_ready,
  input  logic [7:0]               ftdi_rd_fifo_data,
  input  logic                     ftdi_rd_fifo_en,
  output logic                     ftdi_rd_fifo_full,
  output logic                     ftdi_wr_fifo_empty,
  output logic [7:0]               ftdi_wr_data,
  input  logic                     ftdi_wr_fifo_en,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow_err,
  output logic                     underrun_err
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = AW + 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_t;

  // Each entry stores its last byte index (len-1) next to the word.
  logic [DATA_W-1:0] r_mem_word [DEPTH];
  logic [IDX_W-1:0]  r_mem_last [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;

  state_t            r_state;
  logic [DATA_W-1:0] r_word;
  logic [IDX_W-1:0]  r_last;
  logic [IDX_W-1:0]  r_idx;
  logic [7:0]        r_wr_data;
  logic              r_mode;
  logic              r_overflow;
  logic              r_underrun;

  logic              w_full;
  logic              w_fifo_empty;
  logic              w_push_req;
  logic              w_push;
  logic              w_pop;
  logic              w_last_byte;
  logic [DATA_W-1:0] w_push_word;
  logic [IDX_W-1:0]  w_push_last;
  logic [DATA_W-1:0] w_head_word;
  logic [IDX_W-1:0]  w_head_last;

  function automatic logic [7:0] f_byte(input logic [DATA_W-1:0] word,
                                        input logic [IDX_W-1:0]  last,
                                        input logic [IDX_W-1:0]  idx);
    logic [IDX_W-1:0]  sel;
    logic [DATA_W-1:0] sh;
    sel = idx;
    if (MSB_FIRST != 0) sel = last - idx;
    sh = word >> {sel, 3'b000};
    return sh[7:0];
  endfunction

  assign w_full       = (r_count == CW'(DEPTH));
  assign w_fifo_empty = (r_count == '0);
  assign w_push_req   = r_mode ? ftdi_rd_fifo_en : src_valid;
  assign w_push       = w_push_req && !w_full && !sw_clr;
  assign w_push_word  = r_mode ? DATA_W'(ftdi_rd_fifo_data) : src_data;
  assign w_push_last  = r_mode ? '0 : IDX_W'(NB - 1);
  assign w_head_word  = r_mem_word[r_rptr];
  assign w_head_last  = r_mem_last[r_rptr];
  assign w_last_byte  = (r_idx == r_last);
  assign w_pop        = !sw_clr && !w_fifo_empty &&
                        ((r_state == ST_IDLE) ||
                         (ftdi_wr_fifo_en && w_last_byte));

  assign src_ready          = !r_mode && !w_full;
  assign ftdi_rd_fifo_full  = r_mode ? w_full : 1'b1;
  assign ftdi_wr_fifo_empty = (r_state == ST_IDLE);
  assign ftdi_wr_data       = r_wr_data;
  assign level              = r_count;
  assign overflow_err       = r_overflow;
  assign underrun_err       = r_underrun;

  always_ff @(posedge sys_clk) begin
    if (w_push) begin
      r_mem_word[r_wptr] <= w_push_word;
      r_mem_last[r_wptr] <= w_push_last;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (sw_clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= ST_IDLE;
      r_word     <= '0;
      r_last     <= '0;
      r_idx      <= '0;
      r_wr_data  <= '0;
      r_mode     <= 1'b0;
      r_overflow <= 1'b0;
      r_underrun <= 1'b0;
    end else if (sw_clr) begin
      r_state    <= ST_IDLE;
      r_word     <= '0;
      r_last     <= '0;
      r_idx      <= '0;
      r_wr_data  <= '0;
      r_overflow <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (w_push_req && w_full) r_overflow <= 1'b1;
      // Mode may only change when nothing of the old mode is in flight.
      if (r_state == ST_IDLE && w_fifo_empty) r_mode <= loop_en;
      case (r_state)
        ST_IDLE: begin
          if (ftdi_wr_fifo_en) r_underrun <= 1'b1;
          if (w_pop) begin
            r_word    <= w_head_word;
            r_last    <= w_head_last;
            r_idx     <= '0;
            r_wr_data <= f_byte(w_head_word, w_head_last, '0);
            r_state   <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (ftdi_wr_fifo_en) begin
            if (!w_last_byte) begin
              r_idx     <= r_idx + 1'b1;
              r_wr_data <= f_byte(r_word, r_last, r_idx + 1'b1);
            end else if (w_pop) begin
              r_word    <= w_head_word;
              r_last    <= w_head_last;
              r_idx     <= '0;
              r_wr_data <= f_byte(w_head_word, w_head_last, '0);
            end else begin
              r_idx     <= '0;
              r_wr_data <= '0;
              r_state   <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
